// File: rtl/cmp_pkg.sv
// Shared definitions for consumers of the 3-bit comparator result.
// Result encoding is one-hot: bit 2 = a>b, bit 1 = a==b, bit 0 = a<b.
// Provides the code type, the three legal code constants, a one-hot
// check and the state type of the streak-tracking FSM.
package cmp_pkg;

    typedef logic [2:0] cmp_code_t;

    localparam cmp_code_t CMP_GT = 3'b100;
    localparam cmp_code_t CMP_EQ = 3'b010;
    localparam cmp_code_t CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } streak_state_t;

    // True only for the three legal relation codes.
    function automatic logic is_onehot3(input cmp_code_t c);
        return (c == CMP_GT) || (c == CMP_EQ) || (c == CMP_LT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the per-relation tallies.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears the count
//   inc    count up by one this cycle (ignored once at the maximum)
//   clr    synchronous clear, wins over inc
//   q      current count, holds at 2**W-1
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/cmp_streak_tracker.sv
// Consumer of comparator results: keeps saturating gt/eq/lt tallies and
// raises an event when the same relation is accepted STREAK times in a row.
// A pending event blocks further input until the sink takes it.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !ev_valid
//   y                   comparator result {gt,eq,lt}
//   clr                 synchronous clear of tallies, run, err, pending event
//   gt_cnt/eq_cnt/lt_cnt  saturating tallies of accepted results
//   ev_valid/ev_ready   event handshake
//   ev_kind             relation that formed the streak, held after drain
//   err                 sticky: a non-one-hot y was accepted
module cmp_streak_tracker
    import cmp_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int STREAK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       y,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [2:0]       ev_kind,
    output logic             err
);

    localparam int RUN_W = $clog2(STREAK + 1);
    // One extra bit so run+1 can be compared without overflow.
    localparam logic [RUN_W:0] STREAK_L = (RUN_W + 1)'(STREAK);

    streak_state_t  state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    cmp_code_t      last_q, last_d;
    logic           ev_valid_q, ev_valid_d;
    cmp_code_t      ev_kind_q, ev_kind_d;
    logic           err_q, err_d;

    logic           accept;
    logic           code_ok;
    logic           take;
    logic           fire;
    logic [RUN_W:0] run_inc;

    assign in_ready = !ev_valid_q;
    assign accept   = in_valid && in_ready;
    assign code_ok  = is_onehot3(y);
    // clr drops a simultaneous sample entirely.
    assign take     = accept && !clr;
    assign run_inc  = {1'b0, run_q} + 1'b1;

    sat_counter #(.W(CNT_W)) u_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take && code_ok && y[2]),
        .clr   (clr),
        .q     (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_eq (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take && code_ok && y[1]),
        .clr   (clr),
        .q     (eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take && code_ok && y[0]),
        .clr   (clr),
        .q     (lt_cnt)
    );

    // Run tracking FSM. A "new run" starts from a length of one and fires
    // immediately when STREAK is 1.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        fire    = 1'b0;

        if (clr) begin
            state_d = S_IDLE;
            run_d   = '0;
        end else if (take) begin
            if (!code_ok) begin
                state_d = S_IDLE;
                run_d   = '0;
            end else begin
                unique case (state_q)
                    S_RUN: begin
                        if (y == last_q) begin
                            run_d = run_inc[RUN_W-1:0];
                            if (run_inc == STREAK_L) begin
                                fire    = 1'b1;
                                state_d = S_LOCK;
                            end
                        end else begin
                            last_d = y;
                            run_d  = RUN_W'(1);
                            if (STREAK == 1) begin
                                fire    = 1'b1;
                                state_d = S_LOCK;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    end
                    S_LOCK: begin
                        // Repeats of the locked relation neither re-fire
                        // nor advance the run.
                        if (y != last_q) begin
                            last_d = y;
                            run_d  = RUN_W'(1);
                            if (STREAK == 1) begin
                                fire    = 1'b1;
                                state_d = S_LOCK;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    end
                    default: begin
                        last_d = y;
                        run_d  = RUN_W'(1);
                        if (STREAK == 1) begin
                            fire    = 1'b1;
                            state_d = S_LOCK;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                endcase
            end
        end
    end

    // Event and error flags. fire can only happen while no event is
    // pending, so it never collides with a drain.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_kind_d  = ev_kind_q;
        err_d      = err_q;

        if (clr) begin
            ev_valid_d = 1'b0;
            err_d      = 1'b0;
        end else begin
            if (ev_valid_q && ev_ready) begin
                ev_valid_d = 1'b0;
            end
            if (fire) begin
                ev_valid_d = 1'b1;
                ev_kind_d  = y;
            end
            if (take && !code_ok) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_q      <= '0;
            last_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_kind_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            last_q     <= last_d;
            ev_valid_q <= ev_valid_d;
            ev_kind_q  <= ev_kind_d;
            err_q      <= err_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_kind  = ev_kind_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmp_streak_tracker.sv
// Bench for cmp_streak_tracker. Three instances share one input stream:
//   dut 0: CNT_W=8 STREAK=4, dut 1: CNT_W=3 STREAK=4, dut 2: CNT_W=8 STREAK=1.
// The reference model keeps the history of accepted codes since the last
// reset/clear/invalid code and fires when the trailing run of identical
// codes reaches exactly STREAK.
module tb_cmp_streak_tracker;
    import cmp_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] y_s;
    logic       clr;
    logic       ev_ready;

    logic       ir0, ir1, ir2;
    logic [7:0] gt0, eq0, lt0, gt2, eq2, lt2;
    logic [2:0] gt1, eq1, lt1;
    logic       evv0, evv1, evv2;
    logic [2:0] evk0, evk1, evk2;
    logic       err0, err1, err2;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    int         m_cnt  [3][3];
    int         m_max  [3] = '{255, 7, 255};
    int         m_strk [3] = '{4, 4, 1};
    logic       m_evv  [3];
    logic [2:0] m_evk  [3];
    logic       m_err  [3];
    logic [2:0] hist   [3][$];

    cmp_streak_tracker #(.CNT_W(8), .STREAK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .y(y_s),
        .clr(clr), .gt_cnt(gt0), .eq_cnt(eq0), .lt_cnt(lt0), .ev_valid(evv0),
        .ev_ready(ev_ready), .ev_kind(evk0), .err(err0));

    cmp_streak_tracker #(.CNT_W(3), .STREAK(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .y(y_s),
        .clr(clr), .gt_cnt(gt1), .eq_cnt(eq1), .lt_cnt(lt1), .ev_valid(evv1),
        .ev_ready(ev_ready), .ev_kind(evk1), .err(err1));

    cmp_streak_tracker #(.CNT_W(8), .STREAK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .y(y_s),
        .clr(clr), .gt_cnt(gt2), .eq_cnt(eq2), .lt_cnt(lt2), .ev_valid(evv2),
        .ev_ready(ev_ready), .ev_kind(evk2), .err(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int trail(input int i);
        int n;
        int k;
        n = 0;
        k = hist[i].size() - 1;
        while (k >= 0 && hist[i][k] == hist[i][hist[i].size() - 1]) begin
            n++;
            k--;
        end
        return n;
    endfunction

    task automatic model_edge(input int i);
        logic acc;
        int   rel;
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) m_cnt[i][r] = 0;
            m_evv[i] = 1'b0;
            m_evk[i] = 3'b000;
            m_err[i] = 1'b0;
            hist[i].delete();
        end else if (clr) begin
            for (int r = 0; r < 3; r++) m_cnt[i][r] = 0;
            m_evv[i] = 1'b0;
            m_err[i] = 1'b0;
            hist[i].delete();
        end else begin
            acc = in_valid && !m_evv[i];
            if (m_evv[i] && ev_ready) m_evv[i] = 1'b0;
            if (acc) begin
                if ($countones(y_s) == 1) begin
                    rel = y_s[2] ? 0 : (y_s[1] ? 1 : 2);
                    if (m_cnt[i][rel] < m_max[i]) m_cnt[i][rel]++;
                    hist[i].push_back(y_s);
                    if (trail(i) == m_strk[i]) begin
                        m_evv[i] = 1'b1;
                        m_evk[i] = y_s;
                    end
                end else begin
                    m_err[i] = 1'b1;
                    hist[i].delete();
                end
            end
        end
    endtask

    task automatic cmp_one(input int i, input logic [31:0] g, input logic [31:0] e,
                           input logic [31:0] l, input logic ir, input logic ev,
                           input logic [2:0] kd, input logic er);
        chk($sformatf("dut%0d gt_cnt", i), g, m_cnt[i][0]);
        chk($sformatf("dut%0d eq_cnt", i), e, m_cnt[i][1]);
        chk($sformatf("dut%0d lt_cnt", i), l, m_cnt[i][2]);
        chk($sformatf("dut%0d in_ready", i), ir, !m_evv[i]);
        chk($sformatf("dut%0d ev_valid", i), ev, m_evv[i]);
        chk($sformatf("dut%0d ev_kind", i), kd, m_evk[i]);
        chk($sformatf("dut%0d err", i), er, m_err[i]);
    endtask

    task automatic step(input logic iv, input logic [2:0] yy, input logic cl, input logic er);
        in_valid = iv;
        y_s      = yy;
        clr      = cl;
        ev_ready = er;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        cmp_one(0, gt0, eq0, lt0, ir0, evv0, evk0, err0);
        cmp_one(1, 32'(gt1), 32'(eq1), 32'(lt1), ir1, evv1, evk1, err1);
        cmp_one(2, gt2, eq2, lt2, ir2, evv2, evk2, err2);
    endtask

    initial begin
        logic [2:0] yr;
        logic [2:0] onehot_tbl [3];
        onehot_tbl = '{CMP_GT, CMP_EQ, CMP_LT};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        y_s      = 3'b000;
        clr      = 1'b0;
        ev_ready = 1'b0;

        // Reset for two cycles.
        step(1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0);
        chk("reset in_ready", ir0, 1'b1);
        chk("reset ev_valid", evv0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 3'b000, 1'b0, 1'b0);

        // Streak of four eq results, then two more.
        for (int k = 0; k < 4; k++) step(1'b1, CMP_EQ, 1'b0, 1'b1);
        chk("streak eq_cnt", eq0, 8'd4);
        chk("streak ev_valid", evv0, 1'b1);
        chk("streak ev_kind", evk0, CMP_EQ);
        for (int k = 0; k < 3; k++) step(1'b1, CMP_EQ, 1'b0, 1'b1);
        chk("no refire", evv0, 1'b0);

        // Broken run, then backpressure.
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, CMP_GT, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, CMP_LT, 1'b0, 1'b0);
        chk("broken gt_cnt", gt0, 8'd3);
        chk("broken lt_cnt", lt0, 8'd4);
        chk("broken ev_kind", evk0, CMP_LT);
        for (int k = 0; k < 5; k++) step(k[0], CMP_GT, 1'b0, 1'b0);
        chk("held in_ready", ir0, 1'b0);
        chk("held gt_cnt", gt0, 8'd3);
        step(1'b0, 3'b000, 1'b0, 1'b1);

        // Invalid codes.
        step(1'b0, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, CMP_GT, 1'b0, 1'b1);
        step(1'b1, 3'b110, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, CMP_GT, 1'b0, 1'b1);
        chk("invalid err", err0, 1'b1);
        chk("invalid gt_cnt", gt0, 8'd6);
        chk("invalid no event", evv0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b1);
        chk("zero code err", err0, 1'b1);

        // Saturation on the narrow instance, then clear with an accept.
        step(1'b0, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, CMP_LT, 1'b0, 1'b1);
        chk("sat lt_cnt", lt1, 3'd7);
        step(1'b1, CMP_LT, 1'b1, 1'b1);
        chk("clr lt_cnt", lt1, 3'd0);

        // STREAK=1 instance: two distinct events.
        step(1'b0, 3'b000, 1'b1, 1'b1);
        step(1'b1, CMP_GT, 1'b0, 1'b1);
        chk("s1 first kind", evk2, CMP_GT);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b1, CMP_EQ, 1'b0, 1'b1);
        chk("s1 second kind", evk2, CMP_EQ);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b1, CMP_EQ, 1'b0, 1'b1);
        chk("s1 no third", evv2, 1'b0);

        // Reset in mid-run discards the partial run.
        step(1'b0, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, CMP_EQ, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(1'b1, CMP_EQ, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, CMP_EQ, 1'b0, 1'b1);
        chk("midrun no event", evv0, 1'b0);

        // Randomized traffic biased toward repeated codes.
        yr = CMP_EQ;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) yr = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 3) == 0) yr = onehot_tbl[$urandom_range(0, 2)];
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, yr, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
